// File: rtl/mlp_train_sequencer_pkg.sv
// Shared definitions for the MLP training sequencer.
// Holds the loss epsilon, FSM state type and per-output BCE helper.
package Common;

    localparam real epsilon = 1.0e-7;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        UPDATE,
        NEXT,
        EPOCH_END
    } seq_state_t;

    // Binary cross-entropy of one output, clamped away from ln(0).
    function automatic real bce(input real e, input real p);
        return -(e * $ln(p + epsilon)
               + (1.0 - e) * $ln(1.0 - p + epsilon));
    endfunction

endpackage

// File: rtl/mlp_train_sequencer_sample_store.sv
// Dataset memory: one feature vector and one target vector per entry.
// Synchronous write, asynchronous read, contents survive reset.
module sample_store #(
    parameter int inputs  = 2,
    parameter int outputs = 1,
    parameter int depth   = 8,
    localparam int AW     = $clog2(depth)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  real           wvalues_i   [inputs],
    input  real           wexpected_i [outputs],
    input  logic [AW-1:0] raddr_i,
    output real           rvalues_o   [inputs],
    output real           rexpected_o [outputs]
);

    real mem_v_q [depth][inputs];
    real mem_e_q [depth][outputs];

    // Store a full sample on a write strobe; no reset so data persists.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < inputs; i++)
                mem_v_q[waddr_i][i] <= wvalues_i[i];
            for (int o = 0; o < outputs; o++)
                mem_e_q[waddr_i][o] <= wexpected_i[o];
        end
    end

    // Combinational read of the currently addressed sample.
    always_comb begin
        for (int i = 0; i < inputs; i++)
            rvalues_o[i] = mem_v_q[raddr_i][i];
        for (int o = 0; o < outputs; o++)
            rexpected_o[o] = mem_e_q[raddr_i][o];
    end

endmodule

// File: rtl/mlp_train_sequencer.sv
// Training-run sequencer for the MLP: steps a stored dataset through
// the network for N epochs, pulses training and tracks mean BCE loss.
module mlp_train_sequencer
    import Common::*;
#(
    parameter int inputs        = 2,
    parameter int outputs       = 1,
    parameter int max_samples   = 8,
    parameter int settle_cycles = 1,
    localparam int AW           = $clog2(max_samples)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  real           wr_values   [inputs],
    input  real           wr_expected [outputs],
    input  logic [AW:0]   num_samples,
    input  logic [15:0]   num_epochs,
    input  logic          train_enable,
    input  real           lr_in,
    input  logic          start,
    input  logic          abort,
    output real           values      [inputs],
    output real           expected    [outputs],
    output logic          training,
    output real           learning_rate,
    input  real           prediction  [outputs],
    output logic          busy,
    output real           epoch_loss,
    output logic          loss_valid,
    output logic [15:0]   epoch_count,
    output logic          done
);

    seq_state_t    state_q;
    logic [AW-1:0] idx_q;
    logic [3:0]    cnt_q;
    logic [AW:0]   ns_q;
    logic [15:0]   ne_q;
    logic          te_q;
    real           lr_q;
    real           acc_q;
    real           epoch_loss_q;
    logic [15:0]   epoch_count_q;
    logic          training_q;
    logic          busy_q;
    logic          loss_valid_q;
    logic          done_q;
    real           values_q   [inputs];
    real           expected_q [outputs];

    real           rd_values   [inputs];
    real           rd_expected [outputs];
    real           sample_loss;

    sample_store #(
        .inputs  (inputs),
        .outputs (outputs),
        .depth   (max_samples)
    ) u_store (
        .clk         (clk),
        .we_i        (wr_en & ~busy_q),
        .waddr_i     (wr_addr),
        .wvalues_i   (wr_values),
        .wexpected_i (wr_expected),
        .raddr_i     (idx_q),
        .rvalues_o   (rd_values),
        .rexpected_o (rd_expected)
    );

    // Loss of the sample being scored, summed over all outputs.
    always_comb begin
        sample_loss = 0.0;
        for (int o = 0; o < outputs; o++)
            sample_loss = sample_loss + bce(expected_q[o], prediction[o]);
    end

    // Run sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            ns_q          <= '0;
            ne_q          <= '0;
            te_q          <= 1'b0;
            lr_q          <= 0.0;
            acc_q         <= 0.0;
            epoch_loss_q  <= 0.0;
            epoch_count_q <= '0;
            training_q    <= 1'b0;
            busy_q        <= 1'b0;
            loss_valid_q  <= 1'b0;
            done_q        <= 1'b0;
            for (int i = 0; i < inputs; i++)
                values_q[i] <= 0.0;
            for (int o = 0; o < outputs; o++)
                expected_q[o] <= 0.0;
        end else begin
            training_q   <= 1'b0;
            loss_valid_q <= 1'b0;
            done_q       <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            ns_q          <= num_samples;
                            ne_q          <= num_epochs;
                            te_q          <= train_enable;
                            lr_q          <= lr_in;
                            idx_q         <= '0;
                            acc_q         <= 0.0;
                            epoch_count_q <= '0;
                            if (num_samples == '0 || num_epochs == '0) begin
                                done_q       <= 1'b1;
                                epoch_loss_q <= 0.0;
                            end else begin
                                state_q <= APPLY;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    APPLY: begin
                        values_q   <= rd_values;
                        expected_q <= rd_expected;
                        cnt_q      <= 4'(settle_cycles);
                        state_q    <= SETTLE;
                    end
                    SETTLE: begin
                        if (cnt_q <= 4'd1)
                            state_q <= SAMPLE;
                        else
                            cnt_q <= cnt_q - 4'd1;
                    end
                    SAMPLE: begin
                        acc_q <= acc_q + sample_loss;
                        if (te_q) begin
                            training_q <= 1'b1;
                            state_q    <= UPDATE;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                    UPDATE: begin
                        state_q <= NEXT;
                    end
                    NEXT: begin
                        if ({1'b0, idx_q} == ns_q - 1'b1) begin
                            epoch_loss_q  <= acc_q / real'(ns_q);
                            loss_valid_q  <= 1'b1;
                            epoch_count_q <= epoch_count_q + 16'd1;
                            state_q       <= EPOCH_END;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= APPLY;
                        end
                    end
                    EPOCH_END: begin
                        acc_q <= 0.0;
                        idx_q <= '0;
                        if (epoch_count_q == ne_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= APPLY;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign values        = values_q;
    assign expected      = expected_q;
    assign training      = training_q;
    assign learning_rate = lr_q;
    assign busy          = busy_q;
    assign epoch_loss    = epoch_loss_q;
    assign loss_valid    = loss_valid_q;
    assign epoch_count   = epoch_count_q;
    assign done          = done_q;

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Directed bench for mlp_train_sequencer on the XOR dataset.
// Prediction is tied to 0.5, so every sample scores ln(2).
module tb_mlp_train_sequencer;

    localparam real LN2 = 0.693147;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    real         wr_values   [2];
    real         wr_expected [1];
    logic [3:0]  num_samples;
    logic [15:0] num_epochs;
    logic        train_enable;
    real         lr_in;
    logic        start;
    logic        abort;
    real         values      [2];
    real         expected    [1];
    logic        training;
    real         learning_rate;
    real         prediction  [1];
    logic        busy;
    real         epoch_loss;
    logic        loss_valid;
    logic [15:0] epoch_count;
    logic        done;

    int checks;
    int errors;

    int done_k, n_tr, tr_bad, n_lv, lv_k;
    int busy0, tr_abort, busy_ab, tr_ab, ec_ab;
    real lr0, v1_0, e1_0, v5_1, e5_0;

    mlp_train_sequencer #(
        .inputs        (2),
        .outputs       (1),
        .max_samples   (8),
        .settle_cycles (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_values     (wr_values),
        .wr_expected   (wr_expected),
        .num_samples   (num_samples),
        .num_epochs    (num_epochs),
        .train_enable  (train_enable),
        .lr_in         (lr_in),
        .start         (start),
        .abort         (abort),
        .values        (values),
        .expected      (expected),
        .training      (training),
        .learning_rate (learning_rate),
        .prediction    (prediction),
        .busy          (busy),
        .epoch_loss    (epoch_loss),
        .loss_valid    (loss_valid),
        .epoch_count   (epoch_count),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input real obs, input real exp);
        checks++;
        if ((obs - exp) > 1.0e-3 || (exp - obs) > 1.0e-3) begin
            errors++;
            $display("FAIL %s got %f want %f", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input real v0, input real v1, input real e0);
        @(negedge clk);
        wr_en          = 1'b1;
        wr_addr        = 3'(a);
        wr_values[0]   = v0;
        wr_values[1]   = v1;
        wr_expected[0] = e0;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // One run from start; k counts edges after the start edge.
    task automatic run(input int ns, input int ne, input int te,
                       input real lr, input int inject_k,
                       input int abort_k, input int budget);
        logic prev_tr;
        done_k = -1; n_tr = 0; tr_bad = 0; n_lv = 0; lv_k = -1;
        prev_tr = 1'b0;
        @(negedge clk);
        num_samples  = 4'(ns);
        num_epochs   = 16'(ne);
        train_enable = te[0];
        lr_in        = lr;
        start        = 1'b1;
        for (int k = 0; k <= budget; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                busy0 = int'(busy);
                lr0   = learning_rate;
            end
            if (k == 1) begin
                v1_0 = values[0];
                e1_0 = expected[0];
            end
            if (k == 5) begin
                v5_1 = values[1];
                e5_0 = expected[0];
            end
            if (training) n_tr++;
            if (training && prev_tr) tr_bad++;
            prev_tr = training;
            if (loss_valid) begin
                n_lv++;
                lv_k = k;
            end
            if (done) done_k = k;
            if (k == inject_k) begin
                start          = 1'b1;
                num_epochs     = 16'd1;
                wr_en          = 1'b1;
                wr_addr        = 3'd0;
                wr_values[0]   = 9.0;
                wr_values[1]   = 9.0;
                wr_expected[0] = 1.0;
            end
            if (k == inject_k + 1) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (k == abort_k) begin
                tr_abort = int'(training);
                abort    = 1'b1;
            end
            if (k == abort_k + 1) begin
                abort   = 1'b0;
                busy_ab = int'(busy);
                tr_ab   = int'(training);
                ec_ab   = int'(epoch_count);
            end
            if (done_k >= 0) break;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_values[0] = 0.0;
        wr_values[1] = 0.0;
        wr_expected[0] = 0.0;
        num_samples = '0;
        num_epochs = '0;
        train_enable = 1'b0;
        lr_in = 0.0;
        start = 1'b0;
        abort = 1'b0;
        prediction[0] = 0.5;

        #22;
        chk("rst_busy", busy, 0);
        chk("rst_training", training, 0);
        chk("rst_done", done, 0);
        chk("rst_loss_valid", loss_valid, 0);
        chk("rst_epoch_count", epoch_count, 0);
        chk("rst_epoch_loss", epoch_loss, 0.0);
        chk("rst_lr", learning_rate, 0.0);
        chk("rst_values1", values[1], 0.0);
        chk("rst_expected0", expected[0], 0.0);
        @(negedge clk);
        rst = 1'b1;

        wr(0, 0.0, 0.0, 0.0);
        wr(1, 0.0, 1.0, 1.0);
        wr(2, 1.0, 0.0, 1.0);
        wr(3, 1.0, 1.0, 0.0);

        run(4, 1, 0, 0.25, -10, -10, 40);
        chk("eval_busy_after_start", busy0, 1);
        chk("eval_lr", lr0, 0.25);
        chk("eval_values1_s1", v5_1, 1.0);
        chk("eval_expected_s1", e5_0, 1.0);
        chk("eval_done_cycle", done_k, 17);
        chk("eval_training_pulses", n_tr, 0);
        chk("eval_loss_valid_count", n_lv, 1);
        chk("eval_loss_valid_cycle", lv_k, 16);
        chk("eval_epoch_loss", epoch_loss, LN2);
        chk("eval_epoch_count", epoch_count, 1);

        run(4, 3, 1, 0.5, 10, -10, 100);
        chk("train_done_cycle", done_k, 63);
        chk("train_pulses", n_tr, 12);
        chk("train_pulse_width", tr_bad, 0);
        chk("train_loss_valid_count", n_lv, 3);
        chk("train_done_after_lv", done_k - lv_k, 1);
        chk("train_epoch_count", epoch_count, 3);
        chk("train_epoch_loss", epoch_loss, LN2);
        chk("train_busy_idle", busy, 0);

        run(4, 3, 1, 0.5, -10, 34, 60);
        chk("mem_protect_values0", v1_0, 0.0);
        chk("mem_protect_expected0", e1_0, 0.0);
        chk("abort_in_update", tr_abort, 1);
        chk("abort_busy", busy_ab, 0);
        chk("abort_training", tr_ab, 0);
        chk("abort_epoch_count", ec_ab, 1);
        chk("abort_no_done", done_k, -1);

        run(4, 1, 0, 0.25, -10, -10, 40);
        chk("restart_done_cycle", done_k, 17);
        chk("restart_loss_valid", n_lv, 1);

        run(0, 5, 1, 0.5, -10, -10, 3);
        chk("zero_done_cycle", done_k, 0);
        chk("zero_busy", busy0, 0);
        chk("zero_epoch_loss", epoch_loss, 0.0);
        chk("zero_epoch_count", epoch_count, 0);
        chk("zero_loss_valid", n_lv, 0);

        @(negedge clk);
        num_samples  = 4'd4;
        num_epochs   = 16'd1;
        train_enable = 1'b1;
        lr_in        = 0.5;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_values1", values[1], 1.0);
        rst = 1'b0;
        #1;
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_training", training, 0);
        chk("mid_reset_values1", values[1], 0.0);
        chk("mid_reset_expected0", expected[0], 0.0);
        chk("mid_reset_lr", learning_rate, 0.0);
        chk("mid_reset_epoch_count", epoch_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
